// File: rtl/flex_stp_sr_framer.sv
// Serial-to-parallel shift register with word framing, a held output word
// under a valid/ready handshake, and a sticky overflow flag for dropped words.
module flex_stp_sr_framer #(
    parameter int NUM_BITS  = 24,
    parameter bit MSB_FIRST = 1'b0,
    localparam int CW       = $clog2(NUM_BITS + 1)
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                serial_in,
    input  logic                shift_enable,
    input  logic                clear,
    input  logic                word_ready,
    output logic [NUM_BITS-1:0] parallel_out,
    output logic [CW-1:0]       bit_count,
    output logic [NUM_BITS-1:0] word_out,
    output logic                word_valid,
    output logic                overflow
);

    logic [NUM_BITS-1:0] next_sr;
    logic                last_bit;
    logic                can_load;

    generate
        if (MSB_FIRST) begin : g_msb
            assign next_sr = {parallel_out[NUM_BITS-2:0], serial_in};
        end else begin : g_lsb
            assign next_sr = {serial_in, parallel_out[NUM_BITS-1:1]};
        end
    endgenerate

    assign last_bit = (bit_count == CW'(NUM_BITS - 1));
    // A pending word may be replaced only if the consumer takes it this cycle.
    assign can_load = !word_valid || word_ready;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            parallel_out <= '1;
            bit_count    <= '0;
            word_out     <= '0;
            word_valid   <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            if (word_valid && word_ready)
                word_valid <= 1'b0;
            if (clear) begin
                parallel_out <= '1;
                bit_count    <= '0;
                overflow     <= 1'b0;
            end else if (shift_enable) begin
                parallel_out <= next_sr;
                if (last_bit) begin
                    bit_count <= '0;
                    if (can_load) begin
                        word_out   <= next_sr;
                        word_valid <= 1'b1;
                    end else begin
                        overflow <= 1'b1;
                    end
                end else begin
                    bit_count <= bit_count + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_flex_stp_sr_framer.sv
// Bench for flex_stp_sr_framer: three configurations share one stimulus stream
// and are checked every cycle against a bit-history reference model.
module tb_flex_stp_sr_framer;

    logic clk = 1'b0;
    logic n_rst = 1'b1;
    logic serial_in = 1'b0, shift_enable = 1'b0, clear = 1'b0, word_ready = 1'b0;

    logic [23:0] po0, wo0, po1, wo1;
    logic [7:0]  po2, wo2;
    logic [4:0]  bc0, bc1;
    logic [3:0]  bc2;
    logic        wv0, wv1, wv2, ov0, ov1, ov2;

    int vectors = 0;
    int errs = 0;

    flex_stp_sr_framer #(.NUM_BITS(24), .MSB_FIRST(1'b0)) dut0 (
        .clk(clk), .n_rst(n_rst), .serial_in(serial_in), .shift_enable(shift_enable),
        .clear(clear), .word_ready(word_ready), .parallel_out(po0), .bit_count(bc0),
        .word_out(wo0), .word_valid(wv0), .overflow(ov0));
    flex_stp_sr_framer #(.NUM_BITS(24), .MSB_FIRST(1'b1)) dut1 (
        .clk(clk), .n_rst(n_rst), .serial_in(serial_in), .shift_enable(shift_enable),
        .clear(clear), .word_ready(word_ready), .parallel_out(po1), .bit_count(bc1),
        .word_out(wo1), .word_valid(wv1), .overflow(ov1));
    flex_stp_sr_framer #(.NUM_BITS(8), .MSB_FIRST(1'b0)) dut2 (
        .clk(clk), .n_rst(n_rst), .serial_in(serial_in), .shift_enable(shift_enable),
        .clear(clear), .word_ready(word_ready), .parallel_out(po2), .bit_count(bc2),
        .word_out(wo2), .word_valid(wv2), .overflow(ov2));

    always #5 clk = ~clk;

    // Reference model: hist[i][a] is the bit shifted in a shifts ago (a=0 newest).
    int          nb   [3] = '{24, 24, 8};
    bit          msbf [3] = '{1'b0, 1'b1, 1'b0};
    logic [63:0] hist [3];
    int          m_cnt[3];
    logic [63:0] m_wo [3];
    bit          m_wv [3];
    bit          m_ov [3];

    function automatic logic [63:0] m_po(int i);
        logic [63:0] r = '0;
        for (int a = 0; a < nb[i]; a++) begin
            if (msbf[i]) r[a] = hist[i][a];
            else         r[nb[i]-1-a] = hist[i][a];
        end
        return r;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 3; i++) begin
            hist[i] = '1; m_cnt[i] = 0; m_wo[i] = '0; m_wv[i] = 0; m_ov[i] = 0;
        end
    endtask

    task automatic m_step();
        for (int i = 0; i < 3; i++) begin
            bit nwv;
            nwv = m_wv[i] && !word_ready;
            if (clear) begin
                hist[i] = '1; m_cnt[i] = 0; m_ov[i] = 0;
            end else if (shift_enable) begin
                hist[i] = {hist[i][62:0], serial_in};
                m_cnt[i] = m_cnt[i] + 1;
                if (m_cnt[i] == nb[i]) begin
                    m_cnt[i] = 0;
                    if (!m_wv[i] || word_ready) begin
                        m_wo[i] = m_po(i); nwv = 1;
                    end else begin
                        m_ov[i] = 1;
                    end
                end
            end
            m_wv[i] = nwv;
        end
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clk or negedge n_rst);
            if (!n_rst) m_reset();
            else m_step();
        end
    end

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] dut_po(int i);
        return (i == 0) ? 64'(po0) : (i == 1) ? 64'(po1) : 64'(po2);
    endfunction
    function automatic logic [63:0] dut_wo(int i);
        return (i == 0) ? 64'(wo0) : (i == 1) ? 64'(wo1) : 64'(wo2);
    endfunction
    function automatic logic [63:0] dut_misc(int i);
        // {bit_count, word_valid, overflow}
        return (i == 0) ? 64'({bc0, wv0, ov0}) : (i == 1) ? 64'({bc1, wv1, ov1})
                        : 64'({1'b0, bc2, wv2, ov2});
    endfunction

    // Per-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("po[%0d]", i), dut_po(i), m_po(i));
                chk($sformatf("wo[%0d]", i), dut_wo(i), m_wo[i]);
                chk($sformatf("cnt_wv_ov[%0d]", i), dut_misc(i),
                    {57'd0, 5'(m_cnt[i]), m_wv[i], m_ov[i]});
            end
        end
    end

    // One clock of stimulus; returns just after the following falling edge.
    task automatic cyc(bit se, bit si, bit rdy, bit clr);
        shift_enable = se; serial_in = si; word_ready = rdy; clear = clr;
        @(negedge clk);
    endtask

    task automatic send(logic [63:0] w, int n, bit msb, bit rdy);
        for (int k = 0; k < n; k++) cyc(1'b1, msb ? w[n-1-k] : w[k], rdy, 1'b0);
    endtask

    task automatic do_reset();
        n_rst = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        n_rst = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #1 n_rst = 1'b0;
        @(negedge clk);
        chk("reset_po", 64'(po0), 64'hFFFFFF);
        chk("reset_misc", 64'({bc0, wv0, ov0}), 64'd0);
        n_rst = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 1'b0);

        // 1: LSB-first word
        send(64'hA5C3F0, 24, 1'b0, 1'b0);
        chk("t1_wo", 64'(wo0), 64'hA5C3F0);
        chk("t1_po", 64'(po0), 64'hA5C3F0);
        chk("t1_wv", 64'(wv0), 64'd1);

        // 2: MSB-first back-to-back with ready held
        do_reset();
        send(64'hA5C3F0, 24, 1'b1, 1'b1);
        chk("t2_wo_a", 64'(wo1), 64'hA5C3F0);
        send(64'h123456, 24, 1'b1, 1'b1);
        chk("t2_wo_b", 64'(wo1), 64'h123456);
        chk("t2_wv_ov", 64'({wv1, ov1}), 64'b10);

        // 3: overflow while the consumer stalls
        do_reset();
        send(64'h00FF00, 24, 1'b0, 1'b0);
        send(64'hFFFFFF, 24, 1'b0, 1'b0);
        chk("t3_wo", 64'(wo0), 64'h00FF00);
        chk("t3_ov", 64'(ov0), 64'd1);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        chk("t3_wv_drained", 64'(wv0), 64'd0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        chk("t3_ov_cleared", 64'(ov0), 64'd0);

        // 4: clear beats shift
        do_reset();
        send(64'($urandom), 10, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        chk("t4_bc", 64'(bc0), 64'd0);
        chk("t4_po", 64'(po0), 64'hFFFFFF);
        send(64'h0F0F0F, 24, 1'b0, 1'b0);
        chk("t4_wo", 64'(wo0), 64'h0F0F0F);

        // 5: asynchronous reset mid-word
        do_reset();
        for (int k = 0; k < 13; k++) begin
            cyc(1'b1, 1'($urandom), 1'b0, 1'b0);
            cyc(1'b0, 1'($urandom), 1'b0, 1'b0);
        end
        send(64'hFFFFFF, 24, 1'b0, 1'b0);
        send(64'h000000, 13, 1'b0, 1'b0);
        #2 n_rst = 1'b0;
        #1;
        chk("t5_async_po", 64'(po0), 64'hFFFFFF);
        chk("t5_async_misc", 64'({bc0, wv0, ov0}), 64'd0);
        chk("t5_async_wo", 64'(wo0), 64'd0);
        @(negedge clk);
        n_rst = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        send(64'h5A5A33, 24, 1'b0, 1'b0);
        chk("t5_wo", 64'(wo0), 64'h5A5A33);

        // 6: 8-bit, ready exactly on the completing shift with a word pending
        do_reset();
        send(64'hC3, 8, 1'b0, 1'b0);
        chk("t6_wo_a", 64'(wo2), 64'hC3);
        send(64'h3C, 7, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        chk("t6_wo_b", 64'(wo2), 64'h3C);
        chk("t6_wv_ov", 64'({wv2, ov2}), 64'b10);

        // Random traffic
        do_reset();
        for (int k = 0; k < 3000; k++)
            cyc(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom_range(0, 2) == 0),
                $urandom_range(0, 99) == 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
